// File: rtl/pst_mon_pkg.sv
// pst_mon_pkg: shared state encoding, widths and default current levels for pst_transition_monitor.
package pst_mon_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, HOLD, DONE} state_t;
  localparam int LAT_W = 5;
  localparam int IDX_W = 3;
  localparam logic [7:0] CUR_HI_D = 8'd200;
  localparam logic [7:0] CUR_LO_D = 8'd5;
endpackage

// File: rtl/pst_lat_tracker.sv
// pst_lat_tracker: per-channel sample counter and first-hit latch yielding a saturated convergence latency.
module pst_lat_tracker
  import pst_mon_pkg::*;
#(
  parameter int MAX_CYC = 16,
  parameter int ERR_TOL = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [7:0]       err,
  input  logic             window,
  input  logic             clear,
  output logic [LAT_W-1:0] lat
);
  logic [LAT_W-1:0] k, k_hit;
  logic hit;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k <= '0;
      k_hit <= '0;
      hit <= 1'b0;
    end else if (strobe && window) begin
      k <= k + 1'b1;
      if (!hit && err <= 8'(ERR_TOL)) begin
        hit <= 1'b1;
        k_hit <= k + 1'b1;
      end
    end
  end
  // A hit on the final sample itself equals MAX_CYC, so the saturated value covers it.
  assign lat = hit ? k_hit : LAT_W'(MAX_CYC);
endmodule

// File: rtl/pst_transition_monitor.sv
// pst_transition_monitor: current stimulus sequencer and two-channel convergence-latency monitor.
// Optional A-vs-B scoring (a_wins, verdict) is enabled by defining PST_MON_VERDICT_EN.
module pst_transition_monitor
  import pst_mon_pkg::*;
#(
  parameter int CUR_HI     = CUR_HI_D,
  parameter int CUR_LO     = CUR_LO_D,
  parameter int SETTLE_CYC = 30,
  parameter int MAX_CYC    = 16,
  parameter int HOLD_CYC   = 15,
  parameter int ERR_TOL    = 5,
  parameter int N_TRANS    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cycle_start,
  input  logic [7:0]       err_a,
  input  logic [7:0]       err_b,
  output logic [7:0]       input_current,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] trans_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [LAT_W-1:0] rd_lat_a,
  output logic [LAT_W-1:0] rd_lat_b,
  output logic [3:0]       a_wins,
  output logic             verdict
);
  state_t state, state_n;
  logic [15:0] cnt, lim;
  logic [LAT_W-1:0] lat_a, lat_b;
  logic [LAT_W-1:0] mem_a [8];
  logic [LAT_W-1:0] mem_b [8];
  logic launch, running, measuring, phase_end, last_trans;
  assign launch     = start && (state == IDLE || state == DONE);
  assign running    = state == SETTLE || state == MEASURE || state == HOLD;
  assign measuring  = state == MEASURE;
  assign lim        = state == SETTLE ? 16'(SETTLE_CYC) : measuring ? 16'(MAX_CYC) : 16'(HOLD_CYC);
  assign phase_end  = running && cycle_start && cnt == lim - 16'd1;
  assign last_trans = trans_idx == IDX_W'(N_TRANS - 1);
  assign busy       = running;
  assign done       = state == DONE;
  assign rd_lat_a   = mem_a[rd_idx];
  assign rd_lat_b   = mem_b[rd_idx];
  pst_lat_tracker #(.MAX_CYC(MAX_CYC), .ERR_TOL(ERR_TOL)) u_trk_a (
    .clk(clk), .rst(rst), .strobe(cycle_start), .err(err_a),
    .window(measuring), .clear(!measuring), .lat(lat_a)
  );
  pst_lat_tracker #(.MAX_CYC(MAX_CYC), .ERR_TOL(ERR_TOL)) u_trk_b (
    .clk(clk), .rst(rst), .strobe(cycle_start), .err(err_b),
    .window(measuring), .clear(!measuring), .lat(lat_b)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (launch) state_n = SETTLE;
    else if (phase_end) state_n = !measuring ? MEASURE : last_trans ? DONE : HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      cnt <= '0;
      input_current <= rst ? 8'd0 : 8'(CUR_HI);
      trans_idx <= '0;
      for (int i = 0; i < 8; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (running && cycle_start) begin
      cnt <= phase_end ? '0 : cnt + 16'd1;
      if (phase_end && state == SETTLE) begin
        trans_idx <= '0;
        input_current <= 8'(CUR_LO);
      end
      if (phase_end && measuring) begin
        mem_a[trans_idx] <= lat_a;
        mem_b[trans_idx] <= lat_b;
      end
      // Next index odd drives the high level, even drives the low level.
      if (phase_end && state == HOLD) begin
        trans_idx <= trans_idx + 1'b1;
        input_current <= trans_idx[0] ? 8'(CUR_LO) : 8'(CUR_HI);
      end
    end
  end
`ifdef PST_MON_VERDICT_EN
  localparam int PEN = N_TRANS > 1 ? N_TRANS - 2 : 0;
  logic win;
  assign win = lat_a < lat_b;
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      a_wins <= '0;
      verdict <= 1'b0;
    end else if (phase_end && measuring) begin
      if (win) a_wins <= a_wins + 4'd1;
      if (last_trans) verdict <= win || (mem_a[PEN] < mem_b[PEN]);
    end
  end
`else
  assign a_wins = 4'd0;
  assign verdict = 1'b0;
`endif
endmodule

// File: tb/tb_pst_transition_monitor.sv
// tb_pst_transition_monitor: randomized self-checking bench with an arithmetic schedule and latency model.
module tb_pst_transition_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, cycle_start = 1'b0;
  logic [7:0] err_a = '0, err_b = '0;
  logic [7:0] input_current;
  logic busy, done, verdict;
  logic [2:0] trans_idx, rd_idx = '0;
  logic [4:0] rd_lat_a, rd_lat_b;
  logic [3:0] a_wins;
  int vec = 0, bad = 0;
  logic [7:0] ea [6][17];
  logic [7:0] eb [6][17];

  pst_transition_monitor dut (
    .clk(clk), .rst(rst), .start(start), .cycle_start(cycle_start),
    .err_a(err_a), .err_b(err_b), .input_current(input_current),
    .busy(busy), .done(done), .trans_idx(trans_idx), .rd_idx(rd_idx),
    .rd_lat_a(rd_lat_a), .rd_lat_b(rd_lat_b), .a_wins(a_wins), .verdict(verdict)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input bit is_a, input int t);
    for (int k = 1; k <= 16; k++) if ((is_a ? ea[t][k] : eb[t][k]) <= 8'd5) return k;
    return 16;
  endfunction

  // Live transition after p pulses: switches at pulse 30 and every 31 pulses after.
  function automatic logic [7:0] exp_cur(input int p);
    int idx;
    if (p < 30) return 8'd200;
    idx = (p - 30) / 31;
    if (idx > 5) idx = 5;
    return (idx % 2) ? 8'd200 : 8'd5;
  endfunction

  task automatic tick(input logic s, input logic cs, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = s;
    cycle_start = cs;
    err_a = a;
    err_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit collide, input bit poke, input int stop_p);
    int q, t, k, ew;
    bit ev;
    logic [7:0] a, b;
    tick(1'b1, collide, 8'($urandom), 8'($urandom));
    rd_idx = 3'd0;
    #1;
    vec++;
    if (busy !== 1'b1 || done !== 1'b0 || input_current !== 8'd200) begin
      bad++;
      $display("FAIL launch: busy=%b done=%b cur=%0d, want busy=1 done=0 cur=200", busy, done, input_current);
    end
    vec++;
    if (rd_lat_a !== 5'd0 || rd_lat_b !== 5'd0) begin
      bad++;
      $display("FAIL launch_clear: rd_lat_a=%0d rd_lat_b=%0d, want 0 0", rd_lat_a, rd_lat_b);
    end
    for (int p = 1; p <= stop_p; p++) begin
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      if (poke && p == 70) tick(1'b1, 1'b0, 8'($urandom), 8'($urandom));
      a = 8'($urandom);
      b = 8'($urandom);
      if (p > 30) begin
        q = p - 31;
        t = q / 31;
        k = q % 31 + 1;
        if (k <= 16) begin
          a = ea[t][k];
          b = eb[t][k];
        end
      end
      tick(1'b0, 1'b1, a, b);
      vec++;
      if (input_current !== exp_cur(p) || done !== (p == 201) || busy !== (p < 201)) begin
        bad++;
        $display("FAIL pulse %0d: cur=%0d done=%b busy=%b, want cur=%0d done=%b busy=%b",
                 p, input_current, done, busy, exp_cur(p), p == 201, p < 201);
      end
    end
    tick(1'b0, 1'b0, 8'd0, 8'd0);
    if (stop_p == 201) begin
      ew = 0;
      for (int i = 0; i < 8; i++) begin
        rd_idx = 3'(i);
        #1;
        vec++;
        if (rd_lat_a !== (i < 6 ? 5'(lat_of(1, i)) : 5'd0) || rd_lat_b !== (i < 6 ? 5'(lat_of(0, i)) : 5'd0)) begin
          bad++;
          $display("FAIL readback %0d: a=%0d b=%0d, want a=%0d b=%0d", i, rd_lat_a, rd_lat_b,
                   i < 6 ? lat_of(1, i) : 0, i < 6 ? lat_of(0, i) : 0);
        end
        if (i < 6 && lat_of(1, i) < lat_of(0, i)) ew++;
      end
      ev = lat_of(1, 4) < lat_of(0, 4) || lat_of(1, 5) < lat_of(0, 5);
`ifndef PST_MON_VERDICT_EN
      ew = 0;
      ev = 1'b0;
`endif
      vec++;
      if (a_wins !== 4'(ew) || verdict !== ev || trans_idx !== 3'd5) begin
        bad++;
        $display("FAIL score: a_wins=%0d verdict=%b trans_idx=%0d, want %0d %b 5", a_wins, verdict, trans_idx, ew, ev);
      end
    end
  endtask

  task automatic fill_random();
    int ha, hb;
    for (int t = 0; t < 6; t++) begin
      ha = $urandom_range(1, 17);
      hb = $urandom_range(1, 17);
      for (int k = 1; k <= 16; k++) begin
        ea[t][k] = k < ha ? 8'($urandom_range(6, 255)) : k == ha ? 8'($urandom_range(0, 5)) : 8'($urandom);
        eb[t][k] = k < hb ? 8'($urandom_range(6, 255)) : k == hb ? 8'($urandom_range(0, 5)) : 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    cycle_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if (input_current !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || trans_idx !== 3'd0 ||
        a_wins !== 4'd0 || verdict !== 1'b0) begin
      bad++;
      $display("FAIL reset: cur=%0d busy=%b done=%b trans=%0d wins=%0d verdict=%b, want all 0",
               input_current, busy, done, trans_idx, a_wins, verdict);
    end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      vec++;
      if (rd_lat_a !== 5'd0 || rd_lat_b !== 5'd0) begin
        bad++;
        $display("FAIL reset_rd %0d: a=%0d b=%0d, want 0 0", i, rd_lat_a, rd_lat_b);
      end
    end
  endtask

  task automatic test_current_sequence();
    fill_random();
    run(1'b0, 1'b0, 201);
  endtask

  task automatic test_latency_capture();
    for (int t = 0; t < 6; t++)
      for (int k = 1; k <= 16; k++) begin
        ea[t][k] = k >= 3 ? 8'd3 : 8'd100;
        eb[t][k] = k >= 9 ? 8'd4 : 8'd50;
      end
    run(1'b0, 1'b0, 201);
  endtask

  task automatic test_boundary();
    for (int t = 0; t < 6; t++)
      for (int k = 1; k <= 16; k++) begin
        ea[t][k] = k == 16 ? 8'd5 : 8'd6;
        eb[t][k] = 8'($urandom_range(6, 255));
      end
    run(1'b0, 1'b0, 201);
  endtask

  task automatic test_abort();
    fill_random();
    run(1'b0, 1'b1, 96);
    test_reset();
    fill_random();
    run(1'b0, 1'b0, 201);
  endtask

  task automatic test_collision();
    fill_random();
    run(1'b1, 1'b0, 201);
  endtask

  task automatic test_back_to_back();
    repeat (2) begin
      fill_random();
      run(1'b0, 1'b0, 201);
    end
  endtask

  initial begin
    test_reset();
    test_current_sequence();
    test_latency_capture();
    test_boundary();
    test_abort();
    test_collision();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
